// File: rtl/hilo_div_unit_pkg.sv
// Shared definitions for the HI/LO register pair and divide engine: ALU control codes,
// divider FSM state encoding and the iteration count.
package hilo_div_unit_pkg;

  localparam logic [3:0] DIV_CONTROL  = 4'b1010;
  localparam logic [3:0] DIVU_CONTROL = 4'b1011;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

  function automatic logic is_div_ctrl(input logic [3:0] ctrl);
    return (ctrl == DIV_CONTROL) || (ctrl == DIVU_CONTROL);
  endfunction

endpackage

// File: rtl/hilo_div_unit_div_core.sv
// Unsigned restoring-divide datapath: one quotient bit per step, MSB first.
// Quotient bits shift into the dividend register as the dividend bits shift out.
module div_core
  import hilo_div_unit_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] quot_o,
  output logic [W-1:0] rem_o,
  output logic         last_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  logic [W-1:0]     rem_q, rem_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W:0]       rem_sh;
  logic [W:0]       dvs_ext;
  logic [W:0]       rem_sub;

  always_comb begin
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    // 33-bit partial remainder: the remainder is always below the divisor, so the
    // shifted value fits and the compare decides the quotient bit directly.
    rem_sh  = {rem_q, quo_q[W-1]};
    dvs_ext = {1'b0, dvs_q};
    rem_sub = rem_sh - dvs_ext;
    if (load_i) begin
      rem_d = '0;
      quo_d = dividend_i;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      if (rem_sh >= dvs_ext) begin
        rem_d = rem_sub[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b1};
      end else begin
        rem_d = rem_sh[W-1:0];
        quo_d = {quo_q[W-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign quot_o = quo_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == CNT_W'(DIV_CYCLES - 1));

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with an iterative DIV/DIVU engine; div_busy stalls EX while a divide runs.
// Optional HILO_BYPASS_EN: hi_o/lo_o forward the write data in the cycle it is written.
module hilo_div_unit
  import hilo_div_unit_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] DIVZERO_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             annul,
  output logic             div_busy,
  output logic             div_done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       div_state_dbg
);

  div_state_e       state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             load, step, div_wr;
  logic             divisor_zero;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] core_quot, core_rem;
  logic             core_last;

  assign divisor_zero = (divisor == '0);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (div_start) state_d = divisor_zero ? ST_FIX : ST_RUN;
      ST_RUN: begin
        if (annul)          state_d = ST_IDLE;
        else if (core_last) state_d = ST_FIX;
      end
      ST_FIX:  state_d = annul ? ST_IDLE : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; busy/done are registered from the next state.
  always_comb begin
    load   = (state_q == ST_IDLE) && div_start;
    step   = (state_q == ST_RUN) && !annul;
    div_wr = (state_q == ST_FIX) && !annul;
    busy_d = (state_d == ST_RUN) || (state_d == ST_FIX);
    done_d = (state_d == ST_DONE);
  end

  // Signed operands are divided as magnitudes; a zero divisor keeps the raw
  // dividend in the core so it can be returned in HI unchanged.
  always_comb begin
    op_a   = (div_signed && dividend[WIDTH-1] && !divisor_zero) ? -dividend : dividend;
    op_b   = (div_signed && divisor[WIDTH-1]) ? -divisor : divisor;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    if (load) begin
      negq_d = div_signed && !divisor_zero && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      negr_d = div_signed && !divisor_zero && dividend[WIDTH-1];
      dz_d   = divisor_zero;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (div_wr) begin
      hi_d = dz_q ? core_quot  : (negr_q ? -core_rem  : core_rem);
      lo_d = dz_q ? DIVZERO_LO : (negq_q ? -core_quot : core_quot);
    end else begin
      if (hi_we) hi_d = hi_wdata;
      if (lo_we) lo_d = lo_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  div_core #(.W(WIDTH)) u_div_core (
    .clk        (clk),
    .rst_n      (resetn),
    .load_i     (load),
    .step_i     (step),
    .dividend_i (op_a),
    .divisor_i  (op_b),
    .quot_o     (core_quot),
    .rem_o      (core_rem),
    .last_o     (core_last)
  );

`ifdef HILO_BYPASS_EN
  assign hi_o = hi_we ? hi_wdata : hi_q;
  assign lo_o = lo_we ? lo_wdata : lo_q;
`else
  assign hi_o = hi_q;
  assign lo_o = lo_q;
`endif

  assign div_busy      = busy_q;
  assign div_done      = done_q;
  assign div_state_dbg = state_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Scoreboard bench for hilo_div_unit: random and directed DIV/DIVU against a 64-bit arithmetic model.
module tb_hilo_div_unit;

  logic        clk;
  logic        resetn;
  logic        hi_we, lo_we;
  logic [31:0] hi_wdata, lo_wdata;
  logic        div_start, div_signed;
  logic [31:0] dividend, divisor;
  logic        annul;
  logic        div_busy, div_done;
  logic [31:0] hi_o, lo_o;
  logic [1:0]  div_state_dbg;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  hilo_div_unit dut (
    .clk           (clk),
    .resetn        (resetn),
    .hi_we         (hi_we),
    .lo_we         (lo_we),
    .hi_wdata      (hi_wdata),
    .lo_wdata      (lo_wdata),
    .div_start     (div_start),
    .div_signed    (div_signed),
    .dividend      (dividend),
    .divisor       (divisor),
    .annul         (annul),
    .div_busy      (div_busy),
    .div_done      (div_done),
    .hi_o          (hi_o),
    .lo_o          (lo_o),
    .div_state_dbg (div_state_dbg)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Reference: MIPS DIV/DIVU semantics evaluated in 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    sa = sgn ? {{32{a[31]}}, a} : {32'h0, a};
    sb = sgn ? {{32{b[31]}}, b} : {32'h0, b};
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Monitor: every div_done cycle must match the oldest outstanding expectation.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    #1;
    if (resetn && div_done) begin
      logic [63:0] e;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_div_done hi=0x%08h lo=0x%08h", hi_o, lo_o);
      end else if (!prev_done) begin
        e = exp_q.pop_front();
        check("div_hi", hi_o, e[63:32]);
        check("div_lo", lo_o, e[31:0]);
      end
      check("done_single_pulse", {31'b0, prev_done}, 32'd0);
    end
    prev_done = resetn && div_done;
  end

  task automatic write_hilo(input logic [31:0] h, input logic [31:0] l);
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; hi_wdata = h; lo_wdata = l;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
  endtask

  // Issue one divide; hold keeps div_start high until done, fix_we writes HI on the FIX edge,
  // annul_at > 0 aborts in that RUN cycle.
  task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, input bit fix_we, input int annul_at);
    int n, busy_cnt;
    bit seen;
    if (annul_at <= 0) exp_q.push_back(ref_div(sgn, a, b));
    @(negedge clk);
    div_start = 1'b1; div_signed = sgn; dividend = a; divisor = b;
    n = 0; busy_cnt = 0; seen = 0;
    for (int i = 1; i <= 60 && !seen; i++) begin
      @(negedge clk);
      n = i;
      if (i == 1) begin
        dividend = $urandom;
        divisor  = $urandom;
        if (!hold || annul_at > 0) div_start = 1'b0;
      end
      annul = (i == annul_at);
      if (fix_we && i == 33) begin
        hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF;
      end else begin
        hi_we = 1'b0;
      end
      #1;
      if (div_busy) busy_cnt++;
      if (div_done) seen = 1;
    end
    div_start = 1'b0; annul = 1'b0; hi_we = 1'b0;
    if (annul_at > 0) begin
      check("annul_no_done", {31'b0, seen}, 32'd0);
      check("annul_busy_clear", {31'b0, div_busy}, 32'd0);
    end else begin
      check("done_seen", {31'b0, seen}, 32'd1);
      check("done_latency", n, (b == 32'h0) ? 32'd2 : 32'd34);
      check("busy_cycles", busy_cnt, (b == 32'h0) ? 32'd1 : 32'd33);
    end
  endtask

  initial begin
    logic [31:0] a, b;
    logic sgn;
    resetn = 1'b0;
    hi_we = 0; lo_we = 0; hi_wdata = 0; lo_wdata = 0;
    div_start = 0; div_signed = 0; dividend = 0; divisor = 0; annul = 0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hi", hi_o, 32'h0);
    check("reset_lo", lo_o, 32'h0);
    check("reset_busy", {31'b0, div_busy}, 32'd0);
    check("reset_done", {31'b0, div_done}, 32'd0);
    resetn = 1'b1;

    // Write visibility with and without bypass.
    write_hilo(32'h1111_1111, 32'h2222_2222);
    @(negedge clk);
    hi_we = 1'b1; hi_wdata = 32'hDEAD_BEEF;
    #1;
`ifdef HILO_BYPASS_EN
    check("bypass_same_cycle", hi_o, 32'hDEAD_BEEF);
`else
    check("no_bypass_same_cycle", hi_o, 32'h1111_1111);
`endif
    @(negedge clk);
    hi_we = 1'b0;
    #1;
    check("write_next_cycle_hi", hi_o, 32'hDEAD_BEEF);
    check("write_lo_untouched", lo_o, 32'h2222_2222);

    // Reset in the middle of a divide.
    @(negedge clk);
    div_start = 1'b1; div_signed = 1'b0; dividend = 32'd1000; divisor = 32'd7;
    @(negedge clk);
    div_start = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrun_reset_hi", hi_o, 32'h0);
    check("midrun_reset_lo", lo_o, 32'h0);
    check("midrun_reset_busy", {31'b0, div_busy}, 32'd0);
    check("midrun_reset_done", {31'b0, div_done}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    check("after_reset_hi", hi_o, 32'h0);

    // Directed cases.
    run_div(1'b0, 32'd100, 32'd7, 1'b1, 1'b0, 0);
    run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 0);
    run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run_div(1'b1, 32'd5, 32'd0, 1'b1, 1'b0, 0);
    run_div(1'b1, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0, 0);
    run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 0);
    run_div(1'b1, 32'd17, 32'hFFFF_FFFB, 1'b0, 1'b0, 0);
    run_div(1'b0, 32'd1000, 32'd3, 1'b0, 1'b1, 0);

    // Annul during RUN keeps the previous HI/LO.
    write_hilo(32'h1234, 32'h1234);
    run_div(1'b0, 32'd99999, 32'd9, 1'b0, 1'b0, 10);
    #1;
    check("annul_hi_kept", hi_o, 32'h1234);
    check("annul_lo_kept", lo_o, 32'h1234);

    // Randomized divides.
    for (int k = 0; k < 30; k++) begin
      sgn = $urandom_range(0, 1);
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = $urandom_range(1, 15);
        2:       b = 32'hFFFF_FFFF - $urandom_range(0, 15);
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      if (b == 32'h0 && $urandom_range(0, 1) == 0) b = 32'd3;
      run_div(sgn, a, b, bit'($urandom_range(0, 1)), 1'b0, 0);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
